// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux.
// Grants end on last, on a dropped request or on hold timeout; all outputs are flops.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             last,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic             ptr, ptr_n;
  logic             sel_n;
  logic [CNT_W-1:0] cnt_n;
  logic             own_req, oth_req, rel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      sel      <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      // grant/busy come from their own flops so the decode cannot glitch
      gnt0     <= (state_n == G0);
      gnt1     <= (state_n == G1);
      busy     <= (state_n != IDLE);
      hold_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = '0;
    own_req = (state == G1) ? req1 : req0;
    oth_req = (state == G1) ? req0 : req1;
    rel     = last | ~own_req | (hold_cnt == CNT_MAX);
    case (state)
      IDLE: begin
        if (req0 && req1)  state_n = ptr ? G1 : G0;
        else if (req0)     state_n = G0;
        else if (req1)     state_n = G1;
      end
      G0, G1: begin
        if (rel) begin
          ptr_n = (state == G0);
          // handing straight to the other side avoids an idle bubble
          if (oth_req)       state_n = (state == G0) ? G1 : G0;
          else if (own_req)  state_n = state;
          else               state_n = IDLE;
        end else begin
          cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    sel_n = sel;
    if (state_n == G0)      sel_n = 1'b0;
    else if (state_n == G1) sel_n = 1'b1;
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: MAX_HOLD=16 and MAX_HOLD=1 instances
// share stimulus; a cycle model predicts each output vector.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, last = 1'b0;
  logic       sel_a, gnt0_a, gnt1_a, busy_a;
  logic [4:0] cnt_a;
  logic       sel_b, gnt0_b, gnt1_b, busy_b;
  logic [4:0] cnt_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .last(last),
    .sel(sel_a), .gnt0(gnt0_a), .gnt1(gnt1_a), .busy(busy_a), .hold_cnt(cnt_a)
  );

  mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .last(last),
    .sel(sel_b), .gnt0(gnt0_b), .gnt1(gnt1_b), .busy(busy_b), .hold_cnt(cnt_b)
  );

  typedef struct {
    int st;   // 0 idle, 1 owner 0, 2 owner 1
    bit ptr;
    int cnt;
    bit sel;
  } mdl_t;

  typedef struct packed {
    logic       g0, g1, sel, busy;
    logic [4:0] cnt;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$], qb[$];

  function automatic mdl_t mdl_next(mdl_t m, bit r0, bit r1, bit l, int mh);
    mdl_t n = m;
    n.cnt = 0;
    if (m.st == 0) begin
      if (r0 && r1) n.st = m.ptr ? 2 : 1;
      else if (r0)  n.st = 1;
      else if (r1)  n.st = 2;
    end else begin
      bit me_one = (m.st == 2);
      bit mine   = me_one ? r1 : r0;
      bit theirs = me_one ? r0 : r1;
      if (l || !mine || m.cnt == mh - 1) begin
        n.ptr = !me_one;
        if (theirs)    n.st = me_one ? 1 : 2;
        else if (mine) n.st = m.st;
        else           n.st = 0;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    if (n.st == 1) n.sel = 1'b0;
    if (n.st == 2) n.sel = 1'b1;
    return n;
  endfunction

  function automatic exp_t to_exp(mdl_t m);
    exp_t e;
    e.g0   = (m.st == 1);
    e.g1   = (m.st == 2);
    e.sel  = m.sel;
    e.busy = (m.st != 0);
    e.cnt  = 5'(m.cnt);
    return e;
  endfunction

  // drive one cycle of stimulus; prediction goes in at drive time and comes
  // back out once the DUT has clocked it
  task automatic step(input bit r0, input bit r1, input bit l);
    exp_t ea, eb, aa, ab;
    req0 = r0; req1 = r1; last = l;
    ma = mdl_next(ma, r0, r1, l, 16);
    mb = mdl_next(mb, r0, r1, l, 1);
    qa.push_back(to_exp(ma));
    qb.push_back(to_exp(mb));
    @(posedge clk); #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    aa = {gnt0_a, gnt1_a, sel_a, busy_a, cnt_a};
    ab = {gnt0_b, gnt1_b, sel_b, busy_b, cnt_b};
    vectors++;
    if (aa !== ea) begin
      errors++;
      $display("FAIL sb_hold16 got g0g1/sel/busy/cnt=%b want %b", aa, ea);
    end
    vectors++;
    if (ab !== eb) begin
      errors++;
      $display("FAIL sb_hold1 got g0g1/sel/busy/cnt=%b want %b", ab, eb);
    end
    vectors++;
    if ((gnt0_a & gnt1_a) !== 1'b0 || busy_a !== (gnt0_a | gnt1_a) ||
        (gnt0_b & gnt1_b) !== 1'b0 || busy_b !== (gnt0_b | gnt1_b)) begin
      errors++;
      $display("FAIL invariant got a:%b%b%b b:%b%b%b want exclusive grants, busy=or",
               gnt0_a, gnt1_a, busy_a, gnt0_b, gnt1_b, busy_b);
    end
  endtask

  task automatic model_reset();
    ma = '{0, 1'b0, 0, 1'b0};
    mb = '{0, 1'b0, 0, 1'b0};
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({gnt0_a, gnt1_a, sel_a, busy_a, cnt_a} !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold got %b want 0", {gnt0_a, gnt1_a, sel_a, busy_a, cnt_a});
    end
    #4 rst = 1'b0;
    model_reset();
    step(1, 1, 0);
    vectors++;
    if (gnt0_a !== 1'b1 || sel_a !== 1'b0 || cnt_a !== 5'd0) begin
      errors++;
      $display("FAIL reset_first_grant got gnt0=%b sel=%b cnt=%0d want 1 0 0",
               gnt0_a, sel_a, cnt_a);
    end
  endtask

  task automatic test_last_release();
    step(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0);
      vectors++;
      if (gnt1_a !== 1'b1 || sel_a !== 1'b1 || cnt_a !== 5'(k)) begin
        errors++;
        $display("FAIL last_grant%0d got gnt1=%b sel=%b cnt=%0d want 1 1 %0d",
                 k, gnt1_a, sel_a, cnt_a, k);
      end
    end
    step(0, 0, 1);
    vectors++;
    if (busy_a !== 1'b0 || sel_a !== 1'b1 || cnt_a !== 5'd0) begin
      errors++;
      $display("FAIL last_idle got busy=%b sel=%b cnt=%0d want 0 1 0", busy_a, sel_a, cnt_a);
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 64; k++) begin
      step(1, 1, 0);
      vectors++;
      if (gnt0_a !== (((k / 16) % 2) == 0) || cnt_a !== 5'(k % 16)) begin
        errors++;
        $display("FAIL timeout_c%0d got gnt0=%b cnt=%0d want %b %0d",
                 k, gnt0_a, cnt_a, ((k / 16) % 2) == 0, k % 16);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(1, 1, (k > 0) && (k % 3 == 0));
      vectors++;
      if (gnt0_a !== (((k / 3) % 2) == 0) || cnt_a !== 5'(k % 3)) begin
        errors++;
        $display("FAIL alt_c%0d got gnt0=%b cnt=%0d want %b %0d",
                 k, gnt0_a, cnt_a, ((k / 3) % 2) == 0, k % 3);
      end
    end
  endtask

  task automatic test_max_hold1();
    logic prev;
    step(0, 0, 0);
    step(1, 1, 0);
    prev = gnt0_b;
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 0);
      vectors++;
      if (gnt0_b !== ~prev || (gnt0_b ^ gnt1_b) !== 1'b1 || cnt_b !== 5'd0) begin
        errors++;
        $display("FAIL hold1_alt%0d got g0=%b g1=%b cnt=%0d want g0=%b one-hot cnt 0",
                 k, gnt0_b, gnt1_b, cnt_b, ~prev);
      end
      prev = gnt0_b;
    end
  endtask

  task automatic test_drop();
    step(0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0);
    vectors++;
    if (gnt0_a !== 1'b1 || cnt_a !== 5'd5) begin
      errors++;
      $display("FAIL drop_pre got gnt0=%b cnt=%0d want 1 5", gnt0_a, cnt_a);
    end
    step(0, 0, 0);
    vectors++;
    if (gnt0_a !== 1'b0 || busy_a !== 1'b0 || sel_a !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle got gnt0=%b busy=%b sel=%b want 0 0 0", gnt0_a, busy_a, sel_a);
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, 0);
    step(0, 1, 0);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (gnt1_a !== 1'b0 || busy_a !== 1'b0 || sel_a !== 1'b0 || cnt_a !== 5'd0) begin
      errors++;
      $display("FAIL async_clear got gnt1=%b busy=%b sel=%b cnt=%0d want 0 0 0 0",
               gnt1_a, busy_a, sel_a, cnt_a);
    end
    model_reset();
    #1 rst = 1'b0;
    step(1, 1, 0);
    vectors++;
    if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0) begin
      errors++;
      $display("FAIL async_ptr got gnt0=%b gnt1=%b want 1 0", gnt0_a, gnt1_a);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_last_release();
    test_timeout();
    test_back_to_back();
    test_max_hold1();
    test_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
